// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: MA-stage request to word-wide req/gnt/rvalid bus.
// Ports: req_* in, rsp_* out, stall out, mem_* bus side; rst active-low.
module lsu_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h10010000,
  parameter int          SPAN_BYTES = 4096,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  localparam logic [31:0] SPAN = 32'(SPAN_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_R,
    S_RESP
  } state_t;

  state_t st, st_nx;

  logic          we_q;
  logic          uns_q;
  logic [1:0]    width_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0] req_off;
  logic        req_bad;
  logic        accept;
  logic        set_rsp;
  logic        err_d;
  logic [31:0] rdata_d;
  logic        tmo;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic [29:0] word_off;

  assign req_off = req_addr - BASE_ADDR;

  // Unsigned offset compare also rejects addresses below BASE_ADDR.
  assign req_bad = (req_width == 2'b11)
                 | ((req_width == 2'b01) & req_addr[0])
                 | ((req_width == 2'b10) & (req_addr[1:0] != 2'b00))
                 | (req_off >= SPAN);

  assign word_off = addr_q[31:2] - BASE_ADDR[31:2];

  // >= so a late gnt at the last ISSUE cycle still bounds WAIT_R.
  assign tmo = (cnt_q >= TLAST);

  always_comb begin
    be = 4'b0000;
    wd = 32'h0;
    unique case (1'b1)
      (width_q == 2'b00): begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      (width_q == 2'b01): begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      (width_q == 2'b10): begin
        be = 4'b1111;
        wd = wdata_q;
      end
      default: begin
        be = 4'b0000;
        wd = 32'h0;
      end
    endcase
  end

  always_comb begin
    ld_b = 8'h0;
    unique case (addr_q[1:0])
      2'd0: ld_b = mem_rdata[7:0];
      2'd1: ld_b = mem_rdata[15:8];
      2'd2: ld_b = mem_rdata[23:16];
      default: ld_b = mem_rdata[31:24];
    endcase
  end

  assign ld_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_ext = mem_rdata;
    unique case (1'b1)
      (width_q == 2'b00):
        ld_ext = uns_q ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
      (width_q == 2'b01):
        ld_ext = uns_q ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    st_nx   = st;
    accept  = 1'b0;
    set_rsp = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;
    unique case (st)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_bad) begin
            st_nx   = S_RESP;
            set_rsp = 1'b1;
            err_d   = 1'b1;
          end else begin
            st_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          if (we_q) begin
            st_nx   = S_RESP;
            set_rsp = 1'b1;
          end else begin
            st_nx = S_WAIT_R;
          end
        end else if (tmo) begin
          st_nx   = S_RESP;
          set_rsp = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          st_nx   = S_RESP;
          set_rsp = 1'b1;
          rdata_d = ld_ext;
        end else if (tmo) begin
          st_nx   = S_RESP;
          set_rsp = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_IDLE;
    else      st <= st_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      width_q <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        width_q <= req_width;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt_q   <= '0;
      end else if ((st == S_ISSUE) || (st == S_WAIT_R)) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (set_rsp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  assign req_ready = (st == S_IDLE);
  assign rsp_valid = (st == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign stall     = (st == S_ISSUE) | (st == S_WAIT_R)
                   | ((st == S_IDLE) & req_valid);
  assign mem_req   = (st == S_ISSUE);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? word_off : 30'h0;
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_wdata = mem_req ? wd : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: vector table, bus responder, scoreboard.
// Ports: none; prints one summary line.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_width = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_width(req_width), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        issue;
    logic [29:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    int          lat;
    logic        err;
    logic [31:0] xrdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_rsp: got rsp_valid expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic run_vec(vec_t v);
    int cyc = 0;
    int issue_n = 0;
    int wait_n = 0;
    bit granted = 0;
    bit bad_bus = 0;
    bit bad_stall = 0;
    bit saw_req = 0;
    bit done = 0;
    @(negedge clk);
    req_we = v.we;
    req_addr = v.addr;
    req_width = v.width;
    req_unsigned = v.uns;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    mem_rdata = v.rdata;
    #1;
    chk("accept_ready", 32'(req_ready), 32'd1);
    chk("accept_stall", 32'(stall), 32'd1);
    sb.push_back('{err: v.err, rdata: v.xrdata});
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (rsp_valid) begin
        done = 1;
        req_valid = 1'b0;
        chk("latency", 32'(cyc), 32'(v.lat));
        chk("resp_stall", 32'(stall), 32'd0);
      end else begin
        if (!stall) bad_stall = 1;
        if (mem_req) begin
          saw_req = 1;
          if (mem_we !== v.we || mem_addr !== v.maddr ||
              mem_be !== v.be || mem_wdata !== v.mwdata) begin
            bad_bus = 1;
            $display("bus we=%b addr=%h be=%b wd=%h",
                     mem_we, mem_addr, mem_be, mem_wdata);
          end
          if (issue_n == v.gnt_dly) begin
            mem_gnt = 1'b1;
            granted = 1;
          end
          issue_n++;
        end else if (granted) begin
          if (wait_n == v.rv_dly) mem_rvalid = 1'b1;
          wait_n++;
        end
      end
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    req_valid = 1'b0;
    chk("rsp_seen", 32'(done), 32'd1);
    chk("bus_traffic", 32'(saw_req), 32'(v.issue));
    chk("bus_fields", 32'(bad_bus), 32'd0);
    chk("stall_hold", 32'(bad_stall), 32'd0);
  endtask

  function automatic vec_t mk(
    logic we, logic [31:0] addr, logic [1:0] width, logic uns,
    logic [31:0] wdata, int gd, int rd, logic [31:0] rdata,
    logic issue, logic [29:0] maddr, logic [3:0] be,
    logic [31:0] mwd, int lat, logic err, logic [31:0] xr);
    vec_t v;
    v.we = we; v.addr = addr; v.width = width; v.uns = uns;
    v.wdata = wdata; v.gnt_dly = gd; v.rv_dly = rd;
    v.rdata = rdata; v.issue = issue; v.maddr = maddr;
    v.be = be; v.mwdata = mwd; v.lat = lat; v.err = err;
    v.xrdata = xr;
    return v;
  endfunction

  initial begin
    // we addr width uns wdata gnt rv rdata | issue maddr be mwd lat err rdata
    tbl.push_back(mk(1, 32'h10010005, 2'b00, 0, 32'h000000AB, 0, -1, 32'h0,
                     1, 30'h1, 4'b0010, 32'hABABABAB, 2, 0, 32'h0));
    tbl.push_back(mk(0, 32'h10010006, 2'b01, 0, 32'h0, 0, 0, 32'h80FF1234,
                     1, 30'h1, 4'b1100, 32'h0, 3, 0, 32'hFFFF80FF));
    tbl.push_back(mk(0, 32'h10010006, 2'b01, 1, 32'h0, 0, 0, 32'h80FF1234,
                     1, 30'h1, 4'b1100, 32'h0, 3, 0, 32'h000080FF));
    tbl.push_back(mk(0, 32'h10010004, 2'b00, 0, 32'h0, 0, 0, 32'h80FF1234,
                     1, 30'h1, 4'b0001, 32'h0, 3, 0, 32'h00000034));
    tbl.push_back(mk(0, 32'h10010002, 2'b10, 0, 32'h0, 0, 0, 32'h0,
                     0, 30'h0, 4'b0000, 32'h0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 32'h1000FFFC, 2'b10, 0, 32'h0, 0, 0, 32'h0,
                     0, 30'h0, 4'b0000, 32'h0, 1, 1, 32'h0));
    tbl.push_back(mk(1, 32'h10010002, 2'b01, 0, 32'h1234BEEF, 3, -1, 32'h0,
                     1, 30'h0, 4'b1100, 32'hBEEFBEEF, 5, 0, 32'h0));
    tbl.push_back(mk(0, 32'h10010010, 2'b10, 0, 32'h0, 0, -1, 32'h0,
                     1, 30'h4, 4'b1111, 32'h0, 17, 1, 32'h0));
    tbl.push_back(mk(0, 32'h10010FFC, 2'b10, 0, 32'h0, 1, 2, 32'hDEADBEEF,
                     1, 30'h3FF, 4'b1111, 32'h0, 6, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 32'h10010000, 2'b11, 0, 32'h0, 0, 0, 32'h0,
                     0, 30'h0, 4'b0000, 32'h0, 1, 1, 32'h0));
    tbl.push_back(mk(1, 32'h10011000, 2'b00, 0, 32'h55, 0, 0, 32'h0,
                     0, 30'h0, 4'b0000, 32'h0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 32'h10010001, 2'b01, 0, 32'h0, 0, 0, 32'h0,
                     0, 30'h0, 4'b0000, 32'h0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 32'h10010FFF, 2'b00, 0, 32'h0, 0, 0, 32'h9A000000,
                     1, 30'h3FF, 4'b1000, 32'h0, 3, 0, 32'hFFFFFF9A));
    tbl.push_back(mk(1, 32'h10010100, 2'b10, 0, 32'h12345678, 1, -1, 32'h0,
                     1, 30'h40, 4'b1111, 32'h12345678, 3, 0, 32'h0));
    tbl.push_back(mk(0, 32'h10010001, 2'b00, 0, 32'h0, 0, 0, 32'h0000FF00,
                     1, 30'h0, 4'b0010, 32'h0, 3, 0, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 32'h10010008, 2'b10, 0, 32'h0, 15, 0, 32'hCAFEF00D,
                     1, 30'h2, 4'b1111, 32'h0, 18, 0, 32'hCAFEF00D));
    tbl.push_back(mk(1, 32'h10010020, 2'b00, 0, 32'h77, -1, -1, 32'h0,
                     1, 30'h8, 4'b0001, 32'h77777777, 17, 1, 32'h0));
    tbl.push_back(mk(0, 32'h10010022, 2'b01, 1, 32'h0, 2, 1, 32'h8001ABCD,
                     1, 30'h8, 4'b1100, 32'h0, 6, 0, 32'h00008001));

    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
      if (i == 1) begin
        @(negedge clk);
        chk("rdata_hold", rsp_rdata, 32'hFFFF80FF);
        chk("idle_ready", 32'(req_ready), 32'd1);
      end
    end

    // Reset in WAIT_R; a stray rvalid afterwards must be dropped.
    @(negedge clk);
    req_we = 1'b0;
    req_addr = 32'h10010008;
    req_width = 2'b10;
    req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    chk("rw_issue", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rw_wait", 32'(stall), 32'd1);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rw_mem_req", 32'(mem_req), 32'd0);
    chk("rw_ready", 32'(req_ready), 32'd1);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rw_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rw_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
    end
    chk("rw_rdata", rsp_rdata, 32'h0);

    run_vec(tbl[1]);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit between the core's memory-access (MA) stage and a word-wide data memory bus.
- Accepts one access request at a time and checks alignment and address range.
- Generates byte enables, replicates store data across lanes, and extracts and sign/zero-extends load data.
- Drives a req/gnt/rvalid memory handshake with timeout, and stalls the pipeline until the response is ready.

Parameters:
- BASE_ADDR, 32'h10010000, first byte address of the data segment.
- SPAN_BYTES, 4096, size of the legal window; accesses outside [BASE_ADDR, BASE_ADDR+SPAN_BYTES) are errors.
- TIMEOUT, 16, maximum cycles spent in ISSUE+WAIT_R before the access is aborted with an error (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  MA-stage access request.
- req_ready  out  1  unit idle; request is accepted this cycle if req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_width  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  funct3[2]: 1 = zero-extend load (LBU/LHU).
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range, illegal width, or timeout; valid with rsp_valid.
- stall  out  1  pipeline hold.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  30  word index, (addr-BASE_ADDR)>>2.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  bus accepts request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (rst=0, async): state IDLE, timeout counter 0, latched request cleared. All outputs 0 except req_ready=1. A transaction in flight is dropped with no rsp_valid. A later mem_rvalid is ignored.
- States: IDLE, ISSUE, WAIT_R, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/width/unsigned/wdata and check the request.
  - Error if any of: width=11; width=01 and addr[0]=1; width=10 and addr[1:0]!=0; (addr-BASE_ADDR) >= SPAN_BYTES (unsigned compare).
  - On error go to RESP with err=1 and issue no bus traffic. Otherwise go to ISSUE.
- ISSUE:
  - mem_req=1; mem_addr/mem_we/mem_be/mem_wdata held stable until mem_gnt.
  - On mem_gnt, a store goes to RESP and a load goes to WAIT_R.
- WAIT_R:
  - mem_rvalid is sampled only in this state, so the earliest is one cycle after gnt.
  - On mem_rvalid, capture the extracted data and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_err are registered and hold until the next RESP.
- Timeout:
  - Counter clears on entering ISSUE and increments every cycle in ISSUE or WAIT_R.
  - When it reaches TIMEOUT-1 without gnt/rvalid that cycle, go to RESP with err=1, rdata=0, and deassert mem_req.
  - A gnt/rvalid in that same cycle wins: normal completion.
- Byte enables and store data:
  - byte: be = 4'b0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: be = 4'b0011<<(2*addr[1]); wdata = {2{wdata[15:0]}}.
  - word: be = 4'b1111; wdata unchanged.
- Load extraction:
  - byte: mem_rdata>>(8*addr[1:0]), low 8 bits.
  - half: mem_rdata>>(16*addr[1]), low 16 bits.
  - Sign-extend unless req_unsigned=1; req_unsigned is ignored for words.
- stall = (state==ISSUE) | (state==WAIT_R) | (state==IDLE & req_valid). Combinational; 0 in RESP so the core advances with the result.
- req_valid outside IDLE is ignored. The requester must hold its request until rsp_valid.
- Minimum latency:
  - Store: accept cycle 0, gnt in cycle 1, rsp_valid in cycle 2.
  - Load: rvalid in cycle 2, rsp_valid in cycle 3.
  - Error: rsp_valid in cycle 1.

Test Plan:
- Store byte addr 0x10010005, wdata 0x000000AB, gnt immediate -> mem_addr=1, mem_be=4'b0010, mem_wdata=0xABABABAB, mem_we=1; rsp_valid cycle 2, err=0, rdata=0.
- Load half addr 0x10010006, mem_rdata=0x80FF1234 one cycle after gnt -> rsp_rdata=0xFFFF80FF; repeat with req_unsigned=1 -> 0x000080FF; byte load addr 0x10010004 -> 0x00000034.
- Misaligned word addr 0x10010002, and out-of-range addr 0x1000FFFC -> mem_req never asserted; rsp_valid next cycle with err=1, rdata=0.
- gnt delayed 3 cycles on a store -> mem_req and mem_addr/be/wdata stable for all 4 ISSUE cycles; stall=1 throughout; rsp_valid one cycle after gnt.
- Load with rvalid never asserted, TIMEOUT=16 -> rsp_valid with err=1 after 16 cycles in ISSUE+WAIT_R; mem_req low after; next request accepted normally.
- rst pulled low mid-WAIT_R, then rvalid arrives after release -> mem_req=0 immediately, no rsp_valid, req_ready=1, stray rvalid ignored.
